// File: rtl/hog_pkg.sv
// ---------------------------------------------------------------------------
// hog_pkg
// Shared constants and types for the HOG feature pipeline.
//   PIX_W     : input pixel width
//   MAG_I/F   : integer / fraction bits of a weighted-magnitude bin value
//   TAN_W     : width of the gradient-angle comparison operands
//   NUM_BINS  : orientation bins per pixel / per cell (0..160 deg, step 20)
//   CELL_PIX  : pixels per cell (power of two, >= 2)
//   CNT_W     : log2(CELL_PIX), width of the in-cell pixel counter
//   ACC_W     : exact width of a cell-level bin sum (cannot overflow)
// ---------------------------------------------------------------------------
package hog_pkg;

  localparam int PIX_W    = 8;
  localparam int MAG_I    = 9;
  localparam int MAG_F    = 16;
  localparam int TAN_W    = 19;
  localparam int NUM_BINS = 9;
  localparam int CELL_PIX = 64;

  localparam int BIN_W    = MAG_I + MAG_F;
  localparam int CNT_W    = $clog2(CELL_PIX);
  // Summing CELL_PIX values of BIN_W bits needs exactly CNT_W extra bits.
  localparam int ACC_W    = MAG_I + MAG_F + CNT_W;

  typedef logic [BIN_W-1:0] bin_t;
  typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/hist_acc_lane.sv
// ---------------------------------------------------------------------------
// hist_acc_lane
// One orientation-bin accumulator of the cell histogram. Sums the bin value
// of every accepted pixel; on the last pixel of a cell the final sum
// (including that pixel) is copied to the output register and the running
// sum restarts from zero.
// Ports:
//   clk     : clock
//   rst     : asynchronous active-low reset
//   accept  : a pixel is taken this cycle
//   last    : the accepted pixel is the final one of the cell
//   bin     : unsigned fixed-point bin contribution of the pixel
//   hist    : completed cell sum for this bin (holds until next load)
// ---------------------------------------------------------------------------
module hist_acc_lane #(
  parameter int BIN_W = 25,
  parameter int ACC_W = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             last,
  input  logic [BIN_W-1:0] bin,
  output logic [ACC_W-1:0] hist
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] hist_reg;
  logic [ACC_W-1:0] sum;

  // Zero-extend the incoming bin; ACC_W is wide enough that this never wraps.
  assign sum = acc_reg + {{(ACC_W-BIN_W){1'b0}}, bin};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg  <= '0;
      hist_reg <= '0;
    end else if (accept) begin
      if (last) begin
        // Last pixel lands in the output, never in the next cell.
        hist_reg <= sum;
        acc_reg  <= '0;
      end else begin
        acc_reg  <= sum;
      end
    end
  end

  assign hist = hist_reg;

endmodule

// File: rtl/cell_hist_acc.sv
// ---------------------------------------------------------------------------
// cell_hist_acc
// Accumulates the nine per-pixel bin contributions of CELL_PIX consecutive
// pixels into one cell histogram and presents it on a valid/ready output
// through a single-entry buffer, so the next cell accumulates while the
// previous histogram drains.
// Optional feature macro: CELL_IDX_EN -- adds the cell_idx output, a
// modulo-NUM_CELLS label of the histogram currently held in hist.
// Ports:
//   clk        : clock
//   rst        : asynchronous active-low reset
//   in_valid   : bin inputs carry a valid pixel
//   in_ready   : block accepts a pixel this cycle (independent of in_valid)
//   bin0..bin160 : unsigned fixed-point bin contributions of the pixel
//   out_valid  : hist holds a completed cell
//   out_ready  : downstream takes hist
//   hist       : packed histogram, bin0 in the LSBs, bin160 in the MSBs
//   cell_idx   : index of the cell in hist (CELL_IDX_EN only)
// ---------------------------------------------------------------------------
module cell_hist_acc
  import hog_pkg::*;
#(
  parameter int MAG_I     = hog_pkg::MAG_I,
  parameter int MAG_F     = hog_pkg::MAG_F,
  parameter int CELL_PIX  = hog_pkg::CELL_PIX,
  parameter int CNT_W     = $clog2(CELL_PIX),
  parameter int ACC_W     = MAG_I + MAG_F + CNT_W
`ifdef CELL_IDX_EN
  ,
  parameter int NUM_CELLS = 1200,
  parameter int IDX_W     = 11
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MAG_I+MAG_F-1:0]    bin0,
  input  logic [MAG_I+MAG_F-1:0]    bin20,
  input  logic [MAG_I+MAG_F-1:0]    bin40,
  input  logic [MAG_I+MAG_F-1:0]    bin60,
  input  logic [MAG_I+MAG_F-1:0]    bin80,
  input  logic [MAG_I+MAG_F-1:0]    bin100,
  input  logic [MAG_I+MAG_F-1:0]    bin120,
  input  logic [MAG_I+MAG_F-1:0]    bin140,
  input  logic [MAG_I+MAG_F-1:0]    bin160,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_BINS*ACC_W-1:0] hist
`ifdef CELL_IDX_EN
  ,
  output logic [IDX_W-1:0]          cell_idx
`endif
);

  localparam int IN_W = MAG_I + MAG_F;

  logic [CNT_W-1:0] pix_cnt_reg;
  logic             out_valid_reg;
  logic             last_pix;
  logic             accept;
  logic             accept_last;
  logic             drain;

  logic [IN_W-1:0]  bin_arr  [NUM_BINS];
  logic [ACC_W-1:0] lane_out [NUM_BINS];

  assign bin_arr[0] = bin0;
  assign bin_arr[1] = bin20;
  assign bin_arr[2] = bin40;
  assign bin_arr[3] = bin60;
  assign bin_arr[4] = bin80;
  assign bin_arr[5] = bin100;
  assign bin_arr[6] = bin120;
  assign bin_arr[7] = bin140;
  assign bin_arr[8] = bin160;

  // -------------------------------------------------------------------------
  // Handshake. Only the last pixel of a cell needs the output buffer, so
  // stall only when that pixel is next and the buffer is full and not
  // draining this cycle. Non-last pixels always go in.
  // -------------------------------------------------------------------------
  assign last_pix    = (pix_cnt_reg == CNT_W'(CELL_PIX - 1));
  assign drain       = out_valid_reg && out_ready;
  assign in_ready    = !(last_pix && out_valid_reg && !out_ready);
  assign accept      = in_valid && in_ready;
  assign accept_last = accept && last_pix;

  // Pixel counter wraps naturally at CELL_PIX (power of two).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt_reg <= '0;
    end else if (accept) begin
      pix_cnt_reg <= pix_cnt_reg + CNT_W'(1);
    end
  end

  // A new histogram load keeps out_valid high even when the old one retires
  // in the same cycle, giving back-to-back output without a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
    end else if (accept_last) begin
      out_valid_reg <= 1'b1;
    end else if (drain) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;

  // -------------------------------------------------------------------------
  // Nine bin lanes
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_lane
      hist_acc_lane #(
        .BIN_W (IN_W),
        .ACC_W (ACC_W)
      ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
        .last   (last_pix),
        .bin    (bin_arr[gi]),
        .hist   (lane_out[gi])
      );
      assign hist[gi*ACC_W +: ACC_W] = lane_out[gi];
    end
  endgenerate

`ifdef CELL_IDX_EN
  // -------------------------------------------------------------------------
  // Cell index: advances on every retired histogram so that it always labels
  // whatever hist holds (or will hold next).
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] cell_idx_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cell_idx_reg <= '0;
    end else if (drain) begin
      if (cell_idx_reg == IDX_W'(NUM_CELLS - 1)) begin
        cell_idx_reg <= '0;
      end else begin
        cell_idx_reg <= cell_idx_reg + IDX_W'(1);
      end
    end
  end

  assign cell_idx = cell_idx_reg;
`endif

endmodule

// File: tb/tb_cell_hist_acc.sv
// ---------------------------------------------------------------------------
// tb_cell_hist_acc
// Directed bench for cell_hist_acc: single cell, bin isolation, maximum
// values, output backpressure, input gaps, asynchronous mid-cell reset and
// (with CELL_IDX_EN) the cell index wrap.
// ---------------------------------------------------------------------------
module tb_cell_hist_acc;

  localparam int BIN_W = 25;
  localparam int ACC_W = 31;
  localparam int NB    = 9;
  localparam int HW    = NB * ACC_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [BIN_W-1:0]  b [NB];
  logic              out_valid;
  logic              out_ready;
  logic [HW-1:0]     hist;
`ifdef CELL_IDX_EN
  logic [10:0]       cell_idx;
`endif

  int n_cmp = 0;
  int n_err = 0;

  cell_hist_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin0      (b[0]),
    .bin20     (b[1]),
    .bin40     (b[2]),
    .bin60     (b[3]),
    .bin80     (b[4]),
    .bin100    (b[5]),
    .bin120    (b[6]),
    .bin140    (b[7]),
    .bin160    (b[8]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hist      (hist)
`ifdef CELL_IDX_EN
    ,
    .cell_idx  (cell_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] lane(input int k);
    return hist[k*ACC_W +: ACC_W];
  endfunction

  // Present one pixel and hold it until accepted; returns #1 after the
  // accepting edge with in_valid low.
  task automatic send_pix(input logic [BIN_W-1:0] v [NB]);
    bit done;
    done = 1'b0;
    for (int k = 0; k < NB; k++) b[k] = v[k];
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("accept_in_time", {{(HW-1){1'b0}}, done}, 1);
  endtask

  task automatic send_uni(input logic [BIN_W-1:0] val);
    logic [BIN_W-1:0] v [NB];
    for (int k = 0; k < NB; k++) v[k] = val;
    send_pix(v);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [BIN_W-1:0] v [NB];

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < NB; k++) b[k] = '0;

    // ---------------- reset state ----------------
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hist", hist, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- single cell, all bins 1.0 ----------------
    for (int n = 0; n < 63; n++) send_uni(25'h10000);
    chk("single_no_early_valid", out_valid, 0);
    send_uni(25'h10000);
    chk("single_valid", out_valid, 1);
    for (int k = 0; k < NB; k++)
      chk($sformatf("single_lane%0d", k), lane(k), 31'h400000);
    idle_cycle();
    chk("single_pulse_once", out_valid, 0);

    // ---------------- bin isolation: bin40 = n<<16 ----------------
    for (int n = 0; n < 64; n++) begin
      for (int k = 0; k < NB; k++) v[k] = '0;
      v[2] = BIN_W'(n) << 16;
      send_pix(v);
    end
    chk("iso_valid", out_valid, 1);
    for (int k = 0; k < NB; k++)
      chk($sformatf("iso_lane%0d", k), lane(k), (k == 2) ? 31'h7E00000 : 31'h0);
    idle_cycle();

    // ---------------- maximum values ----------------
    for (int n = 0; n < 64; n++) send_uni(25'h1FFFFFF);
    for (int k = 0; k < NB; k++)
      chk($sformatf("max_lane%0d", k), lane(k), 31'h7FFFFFC0);
    idle_cycle();

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    for (int n = 0; n < 64; n++) send_uni(25'h20000);
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_lane0", lane(0), 31'h800000);
    for (int n = 0; n < 63; n++) send_uni(25'h30000);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_lane8", lane(8), 31'h800000);
    for (int k = 0; k < NB; k++) b[k] = 25'h30000;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_stall_in_ready", in_ready, 0);
      chk("bp_stall_lane4", lane(4), 31'h800000);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_b2b_valid", out_valid, 1);
    for (int k = 0; k < NB; k++)
      chk($sformatf("bp_second_lane%0d", k), lane(k), 31'hC00000);
    idle_cycle();
    chk("bp_drained", out_valid, 0);

    // ---------------- random gaps, held output ----------------
    out_ready = 1'b0;
    for (int n = 0; n < 64; n++) begin
      int g;
      g = $urandom_range(0, 3);
      for (int i = 0; i < g; i++) idle_cycle();
      for (int k = 0; k < NB; k++) v[k] = BIN_W'(k + 1) << 16;
      send_pix(v);
    end
    chk("gap_valid", out_valid, 1);
    for (int k = 0; k < NB; k++)
      chk($sformatf("gap_lane%0d", k), lane(k), ACC_W'(k + 1) << 22);

    // ---------------- async reset mid-cell ----------------
    for (int n = 0; n < 30; n++) send_uni(25'h10000);
    chk("mid_hist_stable", lane(0), 31'h10000 << 6);
    chk("mid_valid_before_rst", out_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_hist", hist, 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 63; n++) send_uni(25'h10000);
    chk("post_rst_no_early_valid", out_valid, 0);
    send_uni(25'h10000);
    chk("post_rst_valid", out_valid, 1);
    for (int k = 0; k < NB; k++)
      chk($sformatf("post_rst_lane%0d", k), lane(k), 31'h400000);
    idle_cycle();

`ifdef CELL_IDX_EN
    // ---------------- cell index wrap ----------------
    rst = 1'b0;
    #1;
    chk("idx_rst", cell_idx, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 1202; c++) begin
      for (int n = 0; n < 64; n++) send_uni('0);
      if (c == 0 || c == 1 || c >= 1198)
        chk($sformatf("idx_cell%0d", c), cell_idx, c % 1200);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
